// File: rtl/reaction_timer_mp.sv
// reaction_timer_mp
//   Multi-player reaction timer. After start it waits a pseudo-random delay. Then it
//   lights the LED and times each player's stop press in milliseconds. A stop before
//   the LED counts as a false start. A round ends when every player has a result or
//   when MAX_MS expires. At the end the fastest valid player is reported as the winner.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   start, clear  single-cycle command pulses (clear wins over start)
//   stop          per-player single-cycle stop pulses
//   led           reaction LED, high only while timing
//   state         00 IDLE, 01 WAIT, 10 TIMING, 11 DONE
//   timer_ms      live ms count in TIMING, frozen in DONE, 0 otherwise
//   result        per-player time, player i at [14*i+13:14*i]
//   valid         result[i] captured this round
//   false_start   player i pressed stop during WAIT
//   winner        index of the winning player
//   winner_valid  a non-false-start, non-timeout result exists
//
// Interface contract: start, clear and stop are one-cycle pulses sampled on the
// rising clock edge. There is no back-pressure. A pulse that the current state does
// not accept is dropped.
module reaction_timer_mp #(
  parameter int NPLAYERS     = 2,
  parameter int TICK_DIV     = 100000,
  parameter int MAX_MS       = 1000,
  parameter int DELAY_MIN_MS = 2000,
  parameter int RAND_BITS    = 12,
  parameter int FALSE_VAL    = 9999
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        clear,
  input  logic [NPLAYERS-1:0]                         stop,
  output logic                                        led,
  output logic [1:0]                                  state,
  output logic [13:0]                                 timer_ms,
  output logic [14*NPLAYERS-1:0]                      result,
  output logic [NPLAYERS-1:0]                         valid,
  output logic [NPLAYERS-1:0]                         false_start,
  output logic [((NPLAYERS > 1) ? $clog2(NPLAYERS) : 1)-1:0] winner,
  output logic                                        winner_valid
);

  localparam int WW = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [13:0]   MAX_V     = 14'(MAX_MS);
  localparam logic [13:0]   FALSE_V   = 14'(FALSE_VAL);
  localparam logic [15:0]   DMIN_V    = 16'(DELAY_MIN_MS);
  localparam logic [15:0]   RMASK     = 16'((32'd1 << RAND_BITS) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_TIMING = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  state_e                      state_q, state_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic [TW-1:0]               tick_q, tick_d;
  logic [15:0]                 delay_q, delay_d;
  logic [13:0]                 timer_q, timer_d;
  logic [NPLAYERS-1:0][13:0]   result_q, result_d;
  logic [NPLAYERS-1:0]         valid_q, valid_d;
  logic [NPLAYERS-1:0]         fs_q, fs_d;
  logic [WW-1:0]               winner_q, winner_d;
  logic                        wv_q, wv_d;
  logic                        led_q, led_d;

  logic                        fb;
  logic                        tick;
  logic [WW-1:0]               best_i;
  logic [13:0]                 best_v;
  logic                        found;

  // Winner search. Only players with a real reaction time are eligible. The strict
  // '<' keeps the lowest index on ties.
  always_comb begin
    best_i = '0;
    best_v = MAX_V;
    found  = 1'b0;
    for (int i = 0; i < NPLAYERS; i++) begin
      if (valid_q[i] && !fs_q[i] && (result_q[i] < MAX_V) &&
          (!found || (result_q[i] < best_v))) begin
        found  = 1'b1;
        best_v = result_q[i];
        best_i = WW'(i);
      end
    end
  end

  always_comb begin
    // The LFSR free-runs in every state, so the delay depends on when start arrives.
    fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d   = {lfsr_q[14:0], fb};
    tick     = (tick_q == TICK_LAST);
    tick_d   = tick ? '0 : tick_q + TW'(1);
    state_d  = state_q;
    delay_d  = delay_q;
    timer_d  = timer_q;
    result_d = result_q;
    valid_d  = valid_q;
    fs_d     = fs_q;
    winner_d = winner_q;
    wv_d     = wv_q;

    if (clear) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      result_d = '0;
      valid_d  = '0;
      fs_d     = '0;
      winner_d = '0;
      wv_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_WAIT;
            delay_d  = DMIN_V + (lfsr_q & RMASK);
            timer_d  = '0;
            result_d = '0;
            valid_d  = '0;
            fs_d     = '0;
            winner_d = '0;
            wv_d     = 1'b0;
          end
        end
        S_WAIT: begin
          for (int i = 0; i < NPLAYERS; i++) begin
            if (stop[i]) begin
              result_d[i] = FALSE_V;
              valid_d[i]  = 1'b1;
              fs_d[i]     = 1'b1;
            end
          end
          if (&fs_q) begin
            state_d = S_DONE;
          end else if (delay_q == '0) begin
            state_d = S_TIMING;
            timer_d = '0;
          end else if (tick) begin
            delay_d = delay_q - 16'd1;
            if (delay_q == 16'd1) begin
              state_d = S_TIMING;
              timer_d = '0;
            end
          end
        end
        S_TIMING: begin
          if (&valid_q) begin
            state_d = S_DONE;
          end else if (timer_q >= MAX_V) begin
            // Timeout: anyone still waiting is recorded at the limit.
            state_d = S_DONE;
            for (int i = 0; i < NPLAYERS; i++) begin
              if (!valid_q[i]) begin
                result_d[i] = MAX_V;
                valid_d[i]  = 1'b1;
              end
            end
          end else begin
            for (int i = 0; i < NPLAYERS; i++) begin
              if (stop[i] && !valid_q[i]) begin
                result_d[i] = timer_q;
                valid_d[i]  = 1'b1;
              end
            end
            if (tick) timer_d = timer_q + 14'd1;
          end
        end
        default: begin
        end
      endcase
    end

    // The prescaler restarts on every state change, so the first tick of a state comes a full
    // TICK_DIV cycles after entry.
    if (state_d != state_q) begin
      tick_d = '0;
      if (state_d == S_DONE) begin
        winner_d = found ? best_i : '0;
        wv_d     = found;
      end
    end
    led_d = (state_d == S_TIMING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 16'hACE1;
      tick_q   <= '0;
      delay_q  <= '0;
      timer_q  <= '0;
      result_q <= '0;
      valid_q  <= '0;
      fs_q     <= '0;
      winner_q <= '0;
      wv_q     <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      tick_q   <= tick_d;
      delay_q  <= delay_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      winner_q <= winner_d;
      wv_q     <= wv_d;
      led_q    <= led_d;
    end
  end

  assign state        = state_q;
  assign led          = led_q;
  assign timer_ms     = timer_q;
  assign result       = result_q;
  assign valid        = valid_q;
  assign false_start  = fs_q;
  assign winner       = winner_q;
  assign winner_valid = wv_q;

endmodule
